hamming_decoder: RTL and testbench
==================================

HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter: CNT_W, 16, width of each error-statistics counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_code carries a codeword this cycle.
REQ-005 in_ready  output  1  block accepts in_code this cycle.
REQ-006 in_code  input  7  received codeword: [6]=p1, [5]=p2, [4]=d0, [3]=p3, [2]=d1, [1]=d2, [0]=d3.
REQ-007 out_valid  output  1  out_* fields hold a decoded word.
REQ-008 out_ready  input  1  consumer accepts the decoded word.
REQ-009 out_data  output  4  decoded data, out_data[i]=d(i).
REQ-010 out_syndrome  output  3  {s1,s2,s3} of the word.
REQ-011 out_corrected  output  1  single-bit error corrected.
REQ-012 out_uncorr  output  1  error detected, not correctable; out_data = uncorrected data bits.
REQ-013 cnt_clear  input  1  synchronous clear of both counters.
REQ-014 cnt_corrected  output  CNT_W  saturating count of delivered words with out_corrected=1.
REQ-015 cnt_uncorr  output  CNT_W  saturating count of delivered words with out_uncorr=1.

Function
REQ-016 Syndrome: s1=c6^c4^c2^c1^c0; s2=c5^c4^c2^c1; s3=c3^c4^c2^c0.
REQ-017 Syndrome decode: 000 clean; 100 flip c6; 010 flip c5; 001 flip c3; 110 flip c1 (d2); 101 flip c0 (d3); 111 (d0/d1 ambiguous) and 011 uncorrectable.
REQ-018 Parity flips (100/010/001) leave data unchanged but still assert out_corrected.
REQ-019 out_corrected and out_uncorr never both 1; both 0 for syndrome 000.
REQ-020 Two-stage pipeline: S1 registers code and syndrome; S2 registers decoded outputs; latency 2 cycles from accept to out_valid with no backpressure.
REQ-021 Transfer on valid&ready each side; throughput one word per cycle sustained when out_ready=1.
REQ-022 S2 loads when S2 empty or out_ready=1; S1 loads when S1 empty or S1 advancing; in_ready = NOT s1_valid OR s1_advance (combinational from out_ready permitted).
REQ-023 While out_valid=1 and out_ready=0, all out_* fields hold stable; no word dropped or duplicated.
REQ-024 Counters increment on out_valid&out_ready only; saturate at 2^CNT_W-1, no wrap.
REQ-025 cnt_clear with simultaneous increment: cnt_clear wins, counter = 0.
REQ-026 Multi-bit errors aliasing to a correctable syndrome are miscorrected; no detection guarantee beyond single-bit.

Reset
REQ-027 rst_n low: s1_valid, out_valid, out_data, out_syndrome, out_corrected, out_uncorr, both counters = 0 immediately, regardless of clock.
REQ-028 in_ready = 1 while in reset and first cycle after deassert.
REQ-029 Reset mid-operation discards in-flight words; no partial outputs after deassert.

Structure
REQ-030 Package hamming_pkg: codeword bit-position constants, syndrome code constants (SYN_OK, SYN_P1, SYN_P2, SYN_P3, SYN_D2, SYN_D3, SYN_AMB, SYN_BAD), shared with the encoder.
REQ-031 Sub-module hamming_syndrome: purely combinational 7-bit code -> 3-bit syndrome; pipeline and counters in top.

Verification
REQ-032 Clean: in_code 7'b1011101, out_ready=1 -> 2 cycles later out_data 4'b1011, syndrome 000, corrected 0, uncorr 0.
REQ-033 d2 error: 7'b1011111 -> out_data 4'b1011, syndrome 110, corrected 1; cnt_corrected +1.
REQ-034 d0 error: 7'b1001101 -> syndrome 111, uncorr 1, out_data 4'b1010; cnt_uncorr +1.
REQ-035 Parity error: 7'b1000000 -> out_data 0000, syndrome 100, corrected 1.
REQ-036 Backpressure: stream 16 encoded words, out_ready toggled random 50% -> all 16 delivered in order, outputs stable while stalled, in_ready low when both stages full.
REQ-037 Counter edges: CNT_W=2, 5 correctable words -> cnt_corrected stays 3; cnt_clear during delivery -> 0; rst_n pulse mid-stream -> out_valid 0 and counters 0 at once.

Source files
------------

// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
//   Shared definitions for the Hamming(7,4) encoder/decoder pair.
//   - Codeword bit positions: [6]=p1 [5]=p2 [4]=d0 [3]=p3 [2]=d1 [1]=d2 [0]=d3
//   - Syndrome codes, ordered {s1,s2,s3}
//   - code_data(): extracts the four data bits as {d3,d2,d1,d0}
// ---------------------------------------------------------------------------
package hamming_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  localparam int POS_P1 = 6;
  localparam int POS_P2 = 5;
  localparam int POS_D0 = 4;
  localparam int POS_P3 = 3;
  localparam int POS_D1 = 2;
  localparam int POS_D2 = 1;
  localparam int POS_D3 = 0;

  typedef logic [SYN_W-1:0] syn_t;

  localparam syn_t SYN_OK  = 3'b000;  // no error
  localparam syn_t SYN_P1  = 3'b100;  // p1 flipped
  localparam syn_t SYN_P2  = 3'b010;  // p2 flipped
  localparam syn_t SYN_P3  = 3'b001;  // p3 flipped
  localparam syn_t SYN_D2  = 3'b110;  // d2 flipped
  localparam syn_t SYN_D3  = 3'b101;  // d3 flipped
  localparam syn_t SYN_AMB = 3'b111;  // d0 and d1 share this syndrome
  localparam syn_t SYN_BAD = 3'b011;  // no single-bit error produces this

  function automatic logic [DATA_W-1:0] code_data(input logic [CODE_W-1:0] code);
    return {code[POS_D3], code[POS_D2], code[POS_D1], code[POS_D0]};
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// ---------------------------------------------------------------------------
// hamming_syndrome
//   Purely combinational syndrome generator.
//   Ports:
//     code     in  7  received codeword
//     syndrome out 3  {s1,s2,s3}
// ---------------------------------------------------------------------------
module hamming_syndrome (
  input  logic [6:0] code,
  output logic [2:0] syndrome
);
  import hamming_pkg::*;

  logic s1;
  logic s2;
  logic s3;

  assign s1 = code[POS_P1] ^ code[POS_D0] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D3];
  assign s2 = code[POS_P2] ^ code[POS_D0] ^ code[POS_D1] ^ code[POS_D2];
  assign s3 = code[POS_P3] ^ code[POS_D0] ^ code[POS_D1] ^ code[POS_D3];

  assign syndrome = {s1, s2, s3};

endmodule

// File: rtl/hamming_decoder.sv
// ---------------------------------------------------------------------------
// hamming_decoder
//   Two-stage valid/ready Hamming(7,4) decoder with saturating error counters.
//   Stage 1 holds the codeword and its syndrome, stage 2 holds the decoded
//   result. Words transfer on valid&ready on both sides.
//   Ports:
//     clk            in   1      clock, rising edge
//     rst_n          in   1      asynchronous active-low reset
//     in_valid       in   1      in_code carries a codeword
//     in_ready       out  1      block accepts in_code this cycle
//     in_code        in   7      received codeword
//     out_valid      out  1      out_* hold a decoded word
//     out_ready      in   1      consumer accepts the decoded word
//     out_data       out  4      decoded data, out_data[i] = d(i)
//     out_syndrome   out  3      {s1,s2,s3}
//     out_corrected  out  1      single-bit error corrected
//     out_uncorr     out  1      uncorrectable error, data passed through raw
//     cnt_clear      in   1      synchronous clear of both counters
//     cnt_corrected  out  CNT_W  delivered words with out_corrected=1
//     cnt_uncorr     out  CNT_W  delivered words with out_uncorr=1
// ---------------------------------------------------------------------------
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_corrected,
  output logic             out_uncorr,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorr
);
  import hamming_pkg::*;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&val) ? val : val + one;
  endfunction

  logic                syn_p0;
  syn_t                syn_code_p0;
  logic                vld_p1;
  logic [CODE_W-1:0]   code_p1;
  syn_t                syn_p1;
  logic [DATA_W-1:0]   dec_data;
  logic                dec_corrected;
  logic                dec_uncorr;
  logic                s2_load;
  logic                s1_advance;
  logic                in_fire;
  logic                out_fire;

  // ---- stage 0: combinational syndrome of the incoming word ----
  hamming_syndrome u_syndrome (
    .code     (in_code),
    .syndrome (syn_code_p0)
  );

  assign syn_p0 = |syn_code_p0;

  // Stage 2 refills whenever it is empty or its word leaves this cycle;
  // stage 1 refills whenever it is empty or its word moves into stage 2.
  assign s2_load    = !out_valid || out_ready;
  assign s1_advance = vld_p1 && s2_load;
  assign in_ready   = !vld_p1 || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;

  // ---- stage 1: register codeword and syndrome ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      code_p1 <= in_code;
      syn_p1  <= syn_code_p0;
    end
  end

  // Parity-bit errors leave the data untouched but are still reported as
  // corrected. d0 and d1 share a syndrome, so neither can be repaired.
  always_comb begin
    dec_data      = code_data(code_p1);
    dec_corrected = 1'b0;
    dec_uncorr    = 1'b0;
    case (syn_p1)
      SYN_OK: begin
      end
      SYN_P1, SYN_P2, SYN_P3: begin
        dec_corrected = 1'b1;
      end
      SYN_D2: begin
        dec_corrected = 1'b1;
        dec_data[2]   = ~dec_data[2];
      end
      SYN_D3: begin
        dec_corrected = 1'b1;
        dec_data[3]   = ~dec_data[3];
      end
      default: begin
        dec_uncorr = 1'b1;
      end
    endcase
  end

  // ---- stage 2: register decoded result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_syndrome  <= '0;
      out_corrected <= 1'b0;
      out_uncorr    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data      <= dec_data;
        out_syndrome  <= syn_p1;
        out_corrected <= dec_corrected;
        out_uncorr    <= dec_uncorr;
      end
    end
  end

  // ---- statistics: count delivered words; clear beats increment ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corrected <= '0;
      cnt_uncorr    <= '0;
    end else if (cnt_clear) begin
      cnt_corrected <= '0;
      cnt_uncorr    <= '0;
    end else if (out_fire) begin
      if (out_corrected) begin
        cnt_corrected <= sat_inc(cnt_corrected);
      end
      if (out_uncorr) begin
        cnt_uncorr <= sat_inc(cnt_uncorr);
      end
    end
  end

  // Nonzero-syndrome flag at the input is kept for observability only.
  logic unused_syn_p0;
  assign unused_syn_p0 = syn_p0;

endmodule

// File: tb/tb_hamming_decoder.sv
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [6:0]  in_code = '0;
  logic        out_ready = 1'b0;
  logic        cnt_clear = 1'b0;

  logic        in_ready, out_valid, out_corrected, out_uncorr;
  logic [3:0]  out_data;
  logic [2:0]  out_syndrome;
  logic [15:0] cnt_corrected, cnt_uncorr;

  logic        b_in_ready, b_out_valid, b_out_corrected, b_out_uncorr;
  logic [3:0]  b_out_data;
  logic [2:0]  b_out_syndrome;
  logic [1:0]  b_cnt_corrected, b_cnt_uncorr;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cc = 0;
  int exp_cu = 0;

  logic        obs_early, obs_vld, obs_corr, obs_unc;
  logic [3:0]  obs_data;
  logic [2:0]  obs_syn;
  logic [15:0] obs_cc, obs_cu;
  logic [1:0]  obs_cc2;

  logic [6:0]  tab_code [8];
  logic [3:0]  tab_data [8];
  logic [2:0]  tab_syn  [8];
  logic        tab_corr [8];
  logic        tab_unc  [8];
  string       tab_name [8];

  hamming_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_syndrome(out_syndrome),
    .out_corrected(out_corrected), .out_uncorr(out_uncorr),
    .cnt_clear(cnt_clear), .cnt_corrected(cnt_corrected), .cnt_uncorr(cnt_uncorr)
  );

  hamming_decoder #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_syndrome(b_out_syndrome),
    .out_corrected(b_out_corrected), .out_uncorr(b_out_uncorr),
    .cnt_clear(cnt_clear), .cnt_corrected(b_cnt_corrected), .cnt_uncorr(b_cnt_uncorr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[2] ^ d[3];
    p2 = d[0] ^ d[1] ^ d[2];
    p3 = d[0] ^ d[1] ^ d[3];
    return {p1, p2, d[0], p3, d[1], d[2], d[3]};
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [6:0] code);
    in_valid  = 1'b1;
    in_code   = code;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    obs_early = out_valid;
    tick();
    obs_vld  = out_valid;
    obs_data = out_data;
    obs_syn  = out_syndrome;
    obs_corr = out_corrected;
    obs_unc  = out_uncorr;
    tick();
    obs_cc  = cnt_corrected;
    obs_cu  = cnt_uncorr;
    obs_cc2 = b_cnt_corrected;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL reset out_data: got %b want 0000", out_data); end
    n_vec++; if (out_syndrome !== 3'b000) begin n_bad++; $display("FAIL reset out_syndrome: got %b want 000", out_syndrome); end
    n_vec++; if (out_corrected !== 1'b0) begin n_bad++; $display("FAIL reset out_corrected: got %b want 0", out_corrected); end
    n_vec++; if (out_uncorr !== 1'b0) begin n_bad++; $display("FAIL reset out_uncorr: got %b want 0", out_uncorr); end
    n_vec++; if (cnt_corrected !== 16'd0) begin n_bad++; $display("FAIL reset cnt_corrected: got %0d want 0", cnt_corrected); end
    n_vec++; if (cnt_uncorr !== 16'd0) begin n_bad++; $display("FAIL reset cnt_uncorr: got %0d want 0", cnt_uncorr); end
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset out_valid: got %b want 0", out_valid); end
    @(negedge clk);
    exp_cc = 0;
    exp_cu = 0;
  endtask

  task automatic test_decode();
    tab_code = '{7'b1011101, 7'b1011111, 7'b1001101, 7'b1000000,
                 7'b1011100, 7'b1110101, 7'b1111101, 7'b1010101};
    tab_data = '{4'b1011, 4'b1011, 4'b1010, 4'b0000,
                 4'b1011, 4'b1011, 4'b1011, 4'b1011};
    tab_syn  = '{3'b000, 3'b110, 3'b111, 3'b100,
                 3'b101, 3'b011, 3'b010, 3'b001};
    tab_corr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tab_unc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tab_name = '{"clean", "d2_err", "d0_err", "p1_err",
                 "d3_err", "bad_syn", "p2_err", "p3_err"};
    for (int i = 0; i < 8; i++) begin
      send_word(tab_code[i]);
      if (tab_corr[i]) exp_cc++;
      if (tab_unc[i]) exp_cu++;
      n_vec++; if (obs_early !== 1'b0) begin n_bad++; $display("FAIL %s latency: out_valid %b after 1 cycle, want 0", tab_name[i], obs_early); end
      n_vec++; if (obs_vld !== 1'b1) begin n_bad++; $display("FAIL %s out_valid: got %b want 1", tab_name[i], obs_vld); end
      n_vec++; if (obs_data !== tab_data[i]) begin n_bad++; $display("FAIL %s out_data: got %b want %b", tab_name[i], obs_data, tab_data[i]); end
      n_vec++; if (obs_syn !== tab_syn[i]) begin n_bad++; $display("FAIL %s out_syndrome: got %b want %b", tab_name[i], obs_syn, tab_syn[i]); end
      n_vec++; if (obs_corr !== tab_corr[i]) begin n_bad++; $display("FAIL %s out_corrected: got %b want %b", tab_name[i], obs_corr, tab_corr[i]); end
      n_vec++; if (obs_unc !== tab_unc[i]) begin n_bad++; $display("FAIL %s out_uncorr: got %b want %b", tab_name[i], obs_unc, tab_unc[i]); end
      n_vec++; if (obs_cc !== 16'(exp_cc)) begin n_bad++; $display("FAIL %s cnt_corrected: got %0d want %0d", tab_name[i], obs_cc, exp_cc); end
      n_vec++; if (obs_cu !== 16'(exp_cu)) begin n_bad++; $display("FAIL %s cnt_uncorr: got %0d want %0d", tab_name[i], obs_cu, exp_cu); end
      n_vec++; if (obs_cc2 !== sat2(exp_cc)) begin n_bad++; $display("FAIL %s cnt_corrected(W2): got %0d want %0d", tab_name[i], obs_cc2, sat2(exp_cc)); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc >= 2) begin
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b out_valid cyc %0d: got %b want 1", cyc, out_valid); end
        n_vec++; if (out_data !== 4'(cyc + 1)) begin n_bad++; $display("FAIL b2b out_data cyc %0d: got %h want %h", cyc, out_data, 4'(cyc + 1)); end
      end
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b in_ready cyc %0d: got %b want 1", cyc, in_ready); end
      in_valid = (cyc < 8);
      in_code  = encode(4'(cyc + 3));
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b drained out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int idx_in, idx_out, occ;
    logic prev_stall;
    logic [3:0] prev_data;
    logic [2:0] prev_syn;
    idx_in = 0;
    idx_out = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_syn = '0;
    for (int cyc = 0; cyc < 400 && idx_out < 16; cyc++) begin
      if (prev_stall) begin
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp stall out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== prev_data || out_syndrome !== prev_syn) begin n_bad++; $display("FAIL bp stall hold: got %h/%b want %h/%b", out_data, out_syndrome, prev_data, prev_syn); end
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx_in < 16);
      in_code   = encode(4'(idx_in));
      #1;
      occ = idx_in - idx_out;
      n_vec++; if (in_ready !== !(occ == 2 && !out_ready)) begin n_bad++; $display("FAIL bp in_ready occ %0d out_ready %b: got %b want %b", occ, out_ready, in_ready, !(occ == 2 && !out_ready)); end
      if (out_valid && out_ready) begin
        n_vec++; if (out_data !== 4'(idx_out) || out_syndrome !== 3'b000) begin n_bad++; $display("FAIL bp order word %0d: got %h/%b want %h/000", idx_out, out_data, out_syndrome, 4'(idx_out)); end
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_syn   = out_syndrome;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (idx_out != 16) begin n_bad++; $display("FAIL bp delivered: got %0d words want 16", idx_out); end
    tick();
    tick();
  endtask

  task automatic test_counter_saturation();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    exp_cc = 0;
    exp_cu = 0;
    n_vec++; if (cnt_corrected !== 16'd0 || cnt_uncorr !== 16'd0) begin n_bad++; $display("FAIL clear counters: got %0d/%0d want 0/0", cnt_corrected, cnt_uncorr); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = 7'b1011111;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    exp_cc = 5;
    n_vec++; if (cnt_corrected !== 16'd5) begin n_bad++; $display("FAIL sat cnt_corrected(W16): got %0d want 5", cnt_corrected); end
    n_vec++; if (b_cnt_corrected !== 2'd3) begin n_bad++; $display("FAIL sat cnt_corrected(W2): got %0d want 3", b_cnt_corrected); end
    n_vec++; if (b_cnt_uncorr !== 2'd0) begin n_bad++; $display("FAIL sat cnt_uncorr(W2): got %0d want 0", b_cnt_uncorr); end
  endtask

  task automatic test_clear_during_delivery();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code  = 7'b1011111;
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (cnt_corrected !== 16'd6) begin n_bad++; $display("FAIL clr pre cnt_corrected: got %0d want 6", cnt_corrected); end
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr pre out_valid: got %b want 1", out_valid); end
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    n_vec++; if (cnt_corrected !== 16'd0) begin n_bad++; $display("FAIL clr wins cnt_corrected: got %0d want 0", cnt_corrected); end
    n_vec++; if (b_cnt_corrected !== 2'd0) begin n_bad++; $display("FAIL clr wins cnt_corrected(W2): got %0d want 0", b_cnt_corrected); end
    tick();
    exp_cc = 1;
    n_vec++; if (cnt_corrected !== 16'd1) begin n_bad++; $display("FAIL clr post cnt_corrected: got %0d want 1", cnt_corrected); end
    n_vec++; if (b_cnt_corrected !== 2'd1) begin n_bad++; $display("FAIL clr post cnt_corrected(W2): got %0d want 1", b_cnt_corrected); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code  = 7'b1001101;
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mid full: out_valid %b in_ready %b want 1 0", out_valid, in_ready); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid reset out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 4'h0 || out_uncorr !== 1'b0) begin n_bad++; $display("FAIL mid reset fields: data %b uncorr %b want 0000 0", out_data, out_uncorr); end
    n_vec++; if (cnt_corrected !== 16'd0) begin n_bad++; $display("FAIL mid reset cnt_corrected: got %0d want 0", cnt_corrected); end
    n_vec++; if (b_cnt_corrected !== 2'd0) begin n_bad++; $display("FAIL mid reset cnt_corrected(W2): got %0d want 0", b_cnt_corrected); end
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid reset in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_cc = 0;
    exp_cu = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid after deassert out_valid cyc %0d: got %b want 0", i, out_valid); end
    end
    n_vec++; if (cnt_uncorr !== 16'd0) begin n_bad++; $display("FAIL mid after deassert cnt_uncorr: got %0d want 0", cnt_uncorr); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_counter_saturation();
    test_clear_during_delivery();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
